mem_arbiter: RTL and testbench

//  Shares the single block-wide backing memory between instruction-cache refill and data-cache

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_wait_timer.sv | 24 ++
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the cache-to-memory arbiter.
//   WORD_SIZE / BLOCK_SIZE : address and cache block widths
//   CACHE_OFFSET_LEN       : byte-offset bits inside a block
//   arb_state_e            : arbiter FSM encoding
//   owner_e                : which cache owns the current transfer
package mem_arb_pkg;
  localparam int WORD_SIZE        = 32;
  localparam int BLOCK_SIZE       = 256;
  localparam int CACHE_OFFSET_LEN = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } owner_e;

  // Clear the byte offset so memory always sees a block-aligned address.
  function automatic logic [WORD_SIZE-1:0] block_align(input logic [WORD_SIZE-1:0] a);
    return {a[WORD_SIZE-1:CACHE_OFFSET_LEN], {CACHE_OFFSET_LEN{1'b0}}};
  endfunction
endpackage

// File: rtl/mem_wait_timer.sv
// Loadable 4-bit down-counter timing the memory strobe window.
//   clk, rst_n   : clock, async active-low clear
//   load_i       : load load_val_i (wins over en_i)
//   en_i         : decrement while nonzero
//   load_val_i   : value to load
//   zero_o       : counter is zero
module mem_wait_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       en_i,
  input  logic [3:0] load_val_i,
  output logic       zero_o
);
  logic [3:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     cnt_q <= 4'd0;
    else if (load_i)                cnt_q <= load_val_i;
    else if (en_i && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
  end

  assign zero_o = (cnt_q == 4'd0);
endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the backing memory between icache refill and dcache
// refill/writeback. One transaction at a time: IDLE -> BUSY -> RESP -> IDLE.
//   ic_req/ic_addr -> ic_done/ic_rdata          icache refill port
//   dc_req/dc_we/dc_addr/dc_wdata -> dc_done/dc_rdata   dcache port
//   mem_addr/mem_rd/mem_wr/mem_wdata <- mem_rdata        memory port
// Build option: define ARB_ROUND_ROBIN_EN for round-robin grant on
// simultaneous requests; otherwise dcache has fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ic_req,
  input  logic [WORD_SIZE-1:0]  ic_addr,
  output logic                  ic_done,
  output logic [BLOCK_SIZE-1:0] ic_rdata,
  input  logic                  dc_req,
  input  logic                  dc_we,
  input  logic [WORD_SIZE-1:0]  dc_addr,
  input  logic [BLOCK_SIZE-1:0] dc_wdata,
  output logic                  dc_done,
  output logic [BLOCK_SIZE-1:0] dc_rdata,
  output logic [WORD_SIZE-1:0]  mem_addr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [BLOCK_SIZE-1:0] mem_wdata,
  input  logic [BLOCK_SIZE-1:0] mem_rdata
);
  arb_state_e            state_q, state_d;
  owner_e                owner_q, owner_d, grant_own;
  logic                  we_q, we_d;
  logic [WORD_SIZE-1:0]  addr_q, addr_d;
  logic [BLOCK_SIZE-1:0] wdata_q, wdata_d;
  logic [BLOCK_SIZE-1:0] ic_rdata_q, dc_rdata_q;
  logic                  tmr_load, tmr_zero, busy, rd_cap, any_req;

  assign any_req = ic_req | dc_req;
  assign busy    = (state_q == BUSY);
  // Last strobe cycle: memory data is valid now.
  assign rd_cap  = busy && tmr_zero && !we_q;

`ifdef ARB_ROUND_ROBIN_EN
  owner_e last_q;
  always_comb begin
    if (ic_req && dc_req) grant_own = (last_q == OWN_IC) ? OWN_DC : OWN_IC;
    else                  grant_own = dc_req ? OWN_DC : OWN_IC;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          last_q <= OWN_IC;
    else if (state_q == IDLE && any_req) last_q <= grant_own;
  end
`else
  always_comb grant_own = dc_req ? OWN_DC : OWN_IC;
`endif

  // Counter is loaded with LATENCY-1 so BUSY lasts LATENCY cycles,
  // leaving on the cycle the counter reads zero.
  mem_wait_timer u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (tmr_load),
    .en_i      (busy),
    .load_val_i(4'(MEM_LATENCY - 1)),
    .zero_o    (tmr_zero)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    tmr_load = 1'b0;
    case (state_q)
      IDLE: if (any_req) begin
        owner_d  = grant_own;
        we_d     = (grant_own == OWN_DC) && dc_we;
        addr_d   = block_align((grant_own == OWN_DC) ? dc_addr : ic_addr);
        wdata_d  = (grant_own == OWN_DC) ? dc_wdata : '0;
        tmr_load = 1'b1;
        state_d  = BUSY;
      end
      BUSY:    if (tmr_zero) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= OWN_DC;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      ic_rdata_q <= '0;
      dc_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      if (rd_cap && owner_q == OWN_IC) ic_rdata_q <= mem_rdata;
      if (rd_cap && owner_q == OWN_DC) dc_rdata_q <= mem_rdata;
    end
  end

  // Outputs decode from state so reset forces them low immediately.
  assign mem_rd    = busy && !we_q;
  assign mem_wr    = busy && we_q;
  assign mem_addr  = busy ? addr_q : '0;
  assign mem_wdata = (busy && we_q) ? wdata_q : '0;
  assign ic_done   = (state_q == RESP) && (owner_q == OWN_IC);
  assign dc_done   = (state_q == RESP) && (owner_q == OWN_DC);
  assign ic_rdata  = ic_rdata_q;
  assign dc_rdata  = dc_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         ic_req, dc_req, dc_we, ic_done, dc_done, mem_rd, mem_wr;
  logic [31:0]  ic_addr, dc_addr, mem_addr;
  logic [255:0] dc_wdata, ic_rdata, dc_rdata, mem_wdata, mem_rdata;
  // second instance, MEM_LATENCY=1
  logic         ic1_req, ic1_done, dc1_done, mem1_rd, mem1_wr;
  logic [31:0]  ic1_addr, mem1_addr;
  logic [255:0] ic1_rdata, dc1_rdata, mem1_wdata, mem1_rdata;

  logic [255:0] mem [0:255];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LATENCY(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_rdata(ic_rdata),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_done(dc_done), .dc_rdata(dc_rdata),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .ic_req(ic1_req), .ic_addr(ic1_addr), .ic_done(ic1_done), .ic_rdata(ic1_rdata),
    .dc_req(1'b0), .dc_we(1'b0), .dc_addr(32'd0), .dc_wdata(256'd0),
    .dc_done(dc1_done), .dc_rdata(dc1_rdata),
    .mem_addr(mem1_addr), .mem_rd(mem1_rd), .mem_wr(mem1_wr),
    .mem_wdata(mem1_wdata), .mem_rdata(mem1_rdata)
  );

  // Memory model: block index from address bits [12:5].
  assign mem_rdata = mem_rd ? mem[mem_addr[12:5]] : '0;
  always @(posedge clk) if (mem_wr) mem[mem_addr[12:5]] <= mem_wdata;

  function automatic logic [255:0] pat(input int i);
    logic [255:0] v;
    for (int w = 0; w < 8; w++) v[w*32 +: 32] = 32'hA000_0000 + 32'(i << 8) + 32'(w);
    return v;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Observes one transaction: waits (bounded) for a strobe, counts strobe
  // cycles, and returns in the cycle after the strobes (the done cycle).
  task automatic watch_txn(output bit ok, output int lat, output logic we,
                           output logic [31:0] addr, output int nstb, output bit bad,
                           output logic ic_d, output logic dc_d);
    ok = 0; lat = 0; we = 0; addr = '0; nstb = 0; bad = 0; ic_d = 0; dc_d = 0;
    for (int i = 0; i < 20; i++) begin
      step;
      lat++;
      if (mem_rd || mem_wr) begin ok = 1; break; end
    end
    if (!ok) return;
    we = mem_wr; addr = mem_addr;
    while (nstb < 20 && (mem_rd || mem_wr)) begin
      if ((mem_rd && mem_wr) || ic_done || dc_done || mem_addr !== addr) bad = 1;
      nstb++;
      step;
    end
    ic_d = ic_done; dc_d = dc_done;
  endtask

  task automatic test_reset;
    rst_n = 0;
    ic_req = 0; dc_req = 0; dc_we = 0; ic_addr = '0; dc_addr = '0; dc_wdata = '0;
    ic1_req = 0; ic1_addr = '0;
    step; step;
    checks++; if ({mem_rd, mem_wr, ic_done, dc_done} !== 4'b0) begin errors++; $display("FAIL reset_strobes got %b exp 0000", {mem_rd, mem_wr, ic_done, dc_done}); end
    checks++; if (mem_addr !== 32'd0 || mem_wdata !== 256'd0) begin errors++; $display("FAIL reset_memport got %h exp 0", mem_addr); end
    checks++; if (ic_rdata !== 256'd0 || dc_rdata !== 256'd0) begin errors++; $display("FAIL reset_rdata got %h exp 0", ic_rdata[31:0]); end
    rst_n = 1;
    step;
  endtask

  task automatic test_ic_read;
    bit ok, bad; int lat, nstb; logic we, icd, dcd; logic [31:0] a;
    ic_req = 1; ic_addr = 32'h0000_1234;
    watch_txn(ok, lat, we, a, nstb, bad, icd, dcd);
    checks++; if (!ok || lat != 1) begin errors++; $display("FAIL ic_latency got %0d exp 1 (ok=%0d)", lat, ok); end
    checks++; if (a !== 32'h0000_1220 || we !== 1'b0) begin errors++; $display("FAIL ic_addr got %h we %b exp 00001220 we 0", a, we); end
    checks++; if (nstb != 4 || bad) begin errors++; $display("FAIL ic_strobes got %0d bad %0d exp 4", nstb, bad); end
    checks++; if ({icd, dcd} !== 2'b10) begin errors++; $display("FAIL ic_done got %b exp 10", {icd, dcd}); end
    checks++; if (ic_rdata !== pat(145)) begin errors++; $display("FAIL ic_rdata got %h exp %h", ic_rdata[31:0], pat(145) & 256'hFFFF_FFFF); end
    ic_req = 0;
    step;
    checks++; if (ic_done !== 1'b0 || mem_rd !== 1'b0) begin errors++; $display("FAIL ic_done_pulse got %b %b exp 0 0", ic_done, mem_rd); end
  endtask

  task automatic test_dc_write;
    bit ok, bad; int lat, nstb; logic we, icd, dcd; logic [31:0] a;
    logic [255:0] b;
    b = {8{32'hB0B0_5A5A}};
    dc_req = 1; dc_we = 1; dc_addr = 32'h40; dc_wdata = b;
    watch_txn(ok, lat, we, a, nstb, bad, icd, dcd);
    checks++; if (!ok || a !== 32'h40 || we !== 1'b1) begin errors++; $display("FAIL wb_addr got %h we %b exp 00000040 we 1", a, we); end
    checks++; if (nstb != 4 || bad) begin errors++; $display("FAIL wb_strobes got %0d bad %0d exp 4", nstb, bad); end
    checks++; if ({icd, dcd} !== 2'b01) begin errors++; $display("FAIL wb_done got %b exp 01", {icd, dcd}); end
    dc_req = 0; dc_we = 0;
    step;
    checks++; if (mem[2] !== b) begin errors++; $display("FAIL wb_mem got %h exp %h", mem[2][31:0], b[31:0]); end
    checks++; if (dc_done !== 1'b0) begin errors++; $display("FAIL wb_done_pulse got %b exp 0", dc_done); end
  endtask

  task automatic test_arbitration;
    bit ok, bad; int lat, nstb; logic we, icd, dcd; logic [31:0] a;
    logic [3:0] exp_dc;
`ifdef ARB_ROUND_ROBIN_EN
    exp_dc = 4'b0101;   // bit g = grant g went to dcache
`else
    exp_dc = 4'b0111;
`endif
    rst_n = 0; step; rst_n = 1; step;
    ic_req = 1; ic_addr = 32'h0000_1234;
    dc_req = 1; dc_we = 0; dc_addr = 32'h40;
    for (int g = 0; g < 4; g++) begin
      watch_txn(ok, lat, we, a, nstb, bad, icd, dcd);
      checks++; if (!ok || dcd !== exp_dc[g] || icd !== !exp_dc[g] || nstb != 4) begin
        errors++; $display("FAIL arb_grant%0d got dc %b ic %b n %0d exp dc %b", g, dcd, icd, nstb, exp_dc[g]); end
      if (dcd === 1'b1) begin
        checks++; if (dc_rdata !== {8{32'hB0B0_5A5A}}) begin errors++; $display("FAIL arb_dc_rdata%0d got %h exp b0b05a5a", g, dc_rdata[31:0]); end
      end else begin
        checks++; if (ic_rdata !== pat(145)) begin errors++; $display("FAIL arb_ic_rdata%0d got %h", g, ic_rdata[31:0]); end
      end
      if (g == 2) dc_req = 0;
    end
    ic_req = 0; dc_req = 0;
    step;
  endtask

  task automatic test_reset_midflight;
    bit ok, bad; int lat, nstb; logic we, icd, dcd; logic [31:0] a;
    bit saw_done;
    ic_req = 1; ic_addr = 32'h0000_1234;
    step; step;
    checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL rst_busy2 got %b exp 1", mem_rd); end
    rst_n = 0;
    #1;
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL rst_async_rd got %b exp 0", mem_rd); end
    saw_done = 0;
    for (int i = 0; i < 3; i++) begin step; if (ic_done || dc_done || mem_rd) saw_done = 1; end
    checks++; if (saw_done) begin errors++; $display("FAIL rst_no_done got 1 exp 0"); end
    rst_n = 1;
    watch_txn(ok, lat, we, a, nstb, bad, icd, dcd);
    checks++; if (!ok || nstb != 4 || bad || icd !== 1'b1 || a !== 32'h1220) begin
      errors++; $display("FAIL rst_restart got n %0d ic %b addr %h exp 4 1 00001220", nstb, icd, a); end
    ic_req = 0;
    step;
  endtask

  task automatic test_back_to_back;
    bit ok, bad; int lat, nstb; logic we, icd, dcd; logic [31:0] a;
    logic [2:0] exp_dc, exp_we; logic [31:0] exp_a [3];
    logic [255:0] c;
    c = {8{32'hC3C3_0F0F}};
`ifdef ARB_ROUND_ROBIN_EN
    exp_dc = 3'b101; exp_we = 3'b001;
    exp_a[0] = 32'h80; exp_a[1] = 32'h1220; exp_a[2] = 32'h100;
`else
    exp_dc = 3'b011; exp_we = 3'b001;
    exp_a[0] = 32'h80; exp_a[1] = 32'h100; exp_a[2] = 32'h1220;
`endif
    rst_n = 0; step; rst_n = 1; step;
    ic_req = 1; ic_addr = 32'h0000_1234;
    dc_req = 1; dc_we = 1; dc_addr = 32'h80; dc_wdata = c;
    for (int g = 0; g < 3; g++) begin
      watch_txn(ok, lat, we, a, nstb, bad, icd, dcd);
      checks++; if (!ok || dcd !== exp_dc[g] || we !== exp_we[g] || a !== exp_a[g] || bad) begin
        errors++; $display("FAIL b2b_grant%0d got dc %b we %b addr %h exp dc %b we %b addr %h", g, dcd, we, a, exp_dc[g], exp_we[g], exp_a[g]); end
      if (dcd === 1'b1 && we === 1'b1) begin dc_we = 0; dc_addr = 32'h100; end
      else if (dcd === 1'b1) dc_req = 0;
    end
    ic_req = 0; dc_req = 0;
    step;
    checks++; if (mem[4] !== c) begin errors++; $display("FAIL b2b_wb_mem got %h exp c3c30f0f", mem[4][31:0]); end
    checks++; if (dc_rdata !== pat(8)) begin errors++; $display("FAIL b2b_refill got %h exp %h", dc_rdata[31:0], pat(8) & 256'hFFFF_FFFF); end
  endtask

  task automatic test_latency1;
    mem1_rdata = {8{32'hC0FF_EE01}};
    ic1_req = 1; ic1_addr = 32'h0000_2004;
    step;
    checks++; if (mem1_rd !== 1'b1 || mem1_addr !== 32'h2000) begin errors++; $display("FAIL l1_strobe got %b %h exp 1 00002000", mem1_rd, mem1_addr); end
    step;
    checks++; if (mem1_rd !== 1'b0 || ic1_done !== 1'b1) begin errors++; $display("FAIL l1_done got rd %b done %b exp 0 1", mem1_rd, ic1_done); end
    checks++; if (ic1_rdata !== {8{32'hC0FF_EE01}}) begin errors++; $display("FAIL l1_rdata got %h exp c0ffee01", ic1_rdata[31:0]); end
    step;
    checks++; if (mem1_rd !== 1'b0 || ic1_done !== 1'b0) begin errors++; $display("FAIL l1_idle got rd %b done %b exp 0 0", mem1_rd, ic1_done); end
    step;
    checks++; if (mem1_rd !== 1'b1) begin errors++; $display("FAIL l1_reaccept got %b exp 1", mem1_rd); end
    ic1_req = 0;
    step; step;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = pat(i);
    mem1_rdata = '0;
    test_reset;
    test_ic_read;
    test_dc_write;
    test_arbitration;
    test_reset_midflight;
    test_back_to_back;
    test_latency1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
